axilm_arb: RTL and testbench
============================

# axilm_arb

Round-robin arbiter that shares one AXI-Lite master channel between NUM_REQ local requesters. It sits between several local-bus clients and the single AXI-Lite master's local interface (USR_* strobes). It serialises transactions, one outstanding at a time, and routes the completion data and response back to the granted requester.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT_CYC, 1024, cycles to wait for master completion (used only with timeout feature)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous, active-low reset
- REQ_ENA  in  NUM_REQ  per-requester request level; held high until own REQ_DONE
- REQ_WSTB  in  4*NUM_REQ  byte strobes, slice i at [4*i+:4]; all-zero = read
- REQ_ADDR  in  32*NUM_REQ  address, slice i at [32*i+:32]
- REQ_WDATA  in  32*NUM_REQ  write data, slice i at [32*i+:32]
- REQ_DONE  out  NUM_REQ  one-cycle completion pulse to granted requester
- REQ_RDATA  out  32  read data, broadcast, valid while REQ_DONE is high
- REQ_RRESP  out  2  response, broadcast, valid while REQ_DONE is high
- USR_ENA  out  1  one-cycle transaction strobe to master
- USR_WSTB  out  4  strobes to master
- USR_ADDR  out  32  address to master
- USR_WDATA  out  32  write data to master
- USR_RDATA  in  32  master read data, valid with USR_DONE
- USR_RRESP  in  2  master response, valid with USR_DONE
- USR_DONE  in  1  master completion pulse
- GNT_ID  out  $clog2(NUM_REQ)  index of current/last grant
- BUSY  out  1  high from ISSUE through RESP

## Operation
- States (in axilm_pkg): IDLE, ISSUE, WAIT, RESP.
- IDLE: when any REQ_ENA is high, pick the winner by round-robin. Search starts at (last_gnt+1) mod NUM_REQ. Register GNT_ID and latch the winner's WSTB/ADDR/WDATA into USR_WSTB/ADDR/WDATA, then go to ISSUE.
- ISSUE: USR_ENA=1 for exactly one cycle, then go to WAIT.
- WAIT: on USR_DONE, capture USR_RDATA/USR_RRESP into REQ_RDATA/REQ_RRESP, set REQ_DONE[GNT_ID]=1, then go to RESP.
- RESP: REQ_DONE is cleared and last_gnt is set to GNT_ID. Go to IDLE.
- USR_* address/data outputs hold their latched values until the next grant.
- The requester drops REQ_ENA on the edge after it sees REQ_DONE. A still-high REQ_ENA in IDLE is treated as a new request.
- USR_DONE outside WAIT is ignored.
- Reset values: all outputs 0, state IDLE, last_gnt=NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction: everything returns to reset values immediately. No REQ_DONE is issued, and the in-flight master transaction is abandoned.

## Timing
- REQ_ENA sampled high at edge 0: GNT_ID valid after edge 1; USR_ENA high between edge 1 and edge 2.
- USR_DONE sampled at edge n: REQ_DONE, REQ_RDATA and REQ_RRESP are high/valid between edge n and edge n+1.
- Back-to-back turnaround: minimum 3 cycles from REQ_DONE to the next USR_ENA. This covers RESP, then IDLE, then ISSUE.
- Simultaneous requests: exactly one grant per arbitration. A requester waits at most NUM_REQ-1 transactions.

## Configuration
- AXILM_ARB_TIMEOUT_EN defined:
  - A counter is cleared on entry to WAIT and increments each cycle in WAIT.
  - If it reaches TIMEOUT_CYC-1 without USR_DONE, the arbiter completes with REQ_RRESP=2'b10 (SLVERR), REQ_RDATA=0 and REQ_DONE pulsed, then goes to RESP.
  - A late USR_DONE is ignored.
- AXILM_ARB_TIMEOUT_EN undefined: no counter; WAIT lasts until USR_DONE. TIMEOUT_CYC is unused.

## Structure
- axilm_pkg holds the state enum, AXI response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10) and the data/address width constants.
- Sub-module axilm_rr_pick: combinational round-robin picker. Inputs are the request vector and last_gnt; outputs are the winner index and a valid flag.

## Test plan
- Single read: REQ_ENA[0]=1, WSTB=0, ADDR=0x1000. Expect one USR_ENA pulse with USR_ADDR=0x1000. Master returns USR_DONE with RDATA=0xDEADBEEF, RRESP=0. Expect REQ_DONE[0] pulsed with REQ_RDATA=0xDEADBEEF.
- Contention with NUM_REQ=2: both REQ_ENA high from reset. Grants go 0, 1, 0, 1 across four transactions. GNT_ID toggles, and each REQ_DONE goes only to the matching requester.
- Write pass-through: requester 1 WSTB=4'hF, ADDR=0x20, WDATA=0x12345678. Expect identical values on USR_WSTB/ADDR/WDATA with USR_ENA; master RRESP=2'b10 is returned on REQ_RRESP.
- Stray USR_DONE in IDLE: no REQ_DONE, state stays IDLE, BUSY=0.
- Reset mid-WAIT: assert ARESETn=0. All outputs are 0 immediately, and the next request goes to requester 0.
- Timeout (AXILM_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): withhold USR_DONE. REQ_DONE is pulsed 16 cycles after entering WAIT with RRESP=2'b10 and RDATA=0.

Source files
------------

// File: rtl/axilm_pkg.sv
// Shared types and constants for the AXI-Lite master round-robin arbiter.
package axilm_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/axilm_arb_if.sv
// Requester-side and master-side bus of axilm_arb; modport master is the arbiter's view.
interface axilm_arb_if import axilm_pkg::*; #(parameter int NUM_REQ = 2) ();
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        REQ_ENA;
  logic [NUM_REQ*STRB_W-1:0] REQ_WSTB;
  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR;
  logic [NUM_REQ*DATA_W-1:0] REQ_WDATA;
  logic [NUM_REQ-1:0]        REQ_DONE;
  logic [DATA_W-1:0]         REQ_RDATA;
  logic [1:0]                REQ_RRESP;
  logic                      USR_ENA;
  logic [STRB_W-1:0]         USR_WSTB;
  logic [ADDR_W-1:0]         USR_ADDR;
  logic [DATA_W-1:0]         USR_WDATA;
  logic [DATA_W-1:0]         USR_RDATA;
  logic [1:0]                USR_RRESP;
  logic                      USR_DONE;
  logic [GW-1:0]             GNT_ID;
  logic                      BUSY;

  modport master (
    input  REQ_ENA, REQ_WSTB, REQ_ADDR, REQ_WDATA, USR_RDATA, USR_RRESP, USR_DONE,
    output REQ_DONE, REQ_RDATA, REQ_RRESP, USR_ENA, USR_WSTB, USR_ADDR, USR_WDATA,
           GNT_ID, BUSY
  );

  modport slave (
    output REQ_ENA, REQ_WSTB, REQ_ADDR, REQ_WDATA, USR_RDATA, USR_RRESP, USR_DONE,
    input  REQ_DONE, REQ_RDATA, REQ_RRESP, USR_ENA, USR_WSTB, USR_ADDR, USR_WDATA,
           GNT_ID, BUSY
  );
endinterface

// File: rtl/axilm_rr_pick.sv
// Combinational round-robin picker: first active request after last_gnt, wrapping.
module axilm_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_gnt,
  output logic [GW-1:0]      win,
  output logic               vld
);
  always_comb begin
    win = '0;
    vld = 1'b0;
    // k = NUM_REQ lands back on last_gnt, so a lone requester can win again
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!vld && req[(int'(last_gnt) + k) % NUM_REQ]) begin
        vld = 1'b1;
        win = GW'((int'(last_gnt) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/axilm_arb.sv
// Round-robin arbiter sharing one AXI-Lite master between NUM_REQ requesters.
// Optional watchdog on the master completion: define AXILM_ARB_TIMEOUT_EN.
module axilm_arb import axilm_pkg::*; #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  axilm_arb_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);

  state_t               state;
  logic [GW-1:0]        last_gnt, gnt, pick;
  logic                 pick_vld;
  logic                 usr_ena, busy;
  logic [STRB_W-1:0]    usr_wstb;
  logic [ADDR_W-1:0]    usr_addr;
  logic [DATA_W-1:0]    usr_wdata, req_rdata;
  logic [1:0]           req_rresp;
  logic [NUM_REQ-1:0]   req_done;
  logic                 to_hit;

  axilm_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (bus.REQ_ENA),
    .last_gnt (last_gnt),
    .win      (pick),
    .vld      (pick_vld)
  );

`ifdef AXILM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] to_cnt;

  // Held at zero outside WAIT, so it starts from zero on every WAIT entry
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)          to_cnt <= '0;
    else if (state != WAIT) to_cnt <= '0;
    else                   to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (state == WAIT) && (to_cnt == CW'(TIMEOUT_CYC - 1));
`else
  logic unused_to_cfg;
  assign unused_to_cfg = (TIMEOUT_CYC != 0);
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      last_gnt  <= GW'(NUM_REQ - 1);
      gnt       <= '0;
      usr_ena   <= 1'b0;
      usr_wstb  <= '0;
      usr_addr  <= '0;
      usr_wdata <= '0;
      req_rdata <= '0;
      req_rresp <= RESP_OKAY;
      req_done  <= '0;
      busy      <= 1'b0;
    end else begin
      usr_ena  <= 1'b0;
      req_done <= '0;
      case (state)
        IDLE: if (pick_vld) begin
          gnt       <= pick;
          usr_wstb  <= bus.REQ_WSTB[STRB_W*pick +: STRB_W];
          usr_addr  <= bus.REQ_ADDR[ADDR_W*pick +: ADDR_W];
          usr_wdata <= bus.REQ_WDATA[DATA_W*pick +: DATA_W];
          busy      <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          usr_ena <= 1'b1;
          state   <= WAIT;
        end
        WAIT: if (bus.USR_DONE) begin
          req_rdata     <= bus.USR_RDATA;
          req_rresp     <= bus.USR_RRESP;
          req_done[gnt] <= 1'b1;
          state         <= RESP;
        end else if (to_hit) begin
          req_rdata     <= '0;
          req_rresp     <= RESP_SLVERR;
          req_done[gnt] <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          last_gnt <= gnt;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.USR_ENA   = usr_ena;
  assign bus.USR_WSTB  = usr_wstb;
  assign bus.USR_ADDR  = usr_addr;
  assign bus.USR_WDATA = usr_wdata;
  assign bus.REQ_DONE  = req_done;
  assign bus.REQ_RDATA = req_rdata;
  assign bus.REQ_RRESP = req_rresp;
  assign bus.GNT_ID    = gnt;
  assign bus.BUSY      = busy;
endmodule

// File: tb/tb_axilm_arb.sv
// Directed self-checking bench for axilm_arb (NUM_REQ=2, TIMEOUT_CYC=16).
module tb_axilm_arb;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  axilm_arb_if #(.NUM_REQ(NR)) bus ();

  axilm_arb #(.NUM_REQ(NR), .TIMEOUT_CYC(16)) dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Observations from the model master in serve()
  logic        o_seen, o_ena2;
  int          o_wcyc;
  logic [31:0] o_addr, o_wdata, o_rd;
  logic [3:0]  o_wstb;
  logic [0:0]  o_gnt;
  logic [1:0]  o_dv, o_rr;

  // Wait (bounded) for USR_ENA, then answer with USR_DONE in the next cycle
  task serve(input logic [31:0] rd, input logic [1:0] rr);
    o_seen = 1'b0; o_wcyc = 0; o_addr = '0; o_wdata = '0; o_wstb = '0; o_gnt = '0;
    o_ena2 = 1'b0; o_dv = '0; o_rd = '0; o_rr = '0;
    for (int i = 0; i < 20 && !o_seen; i++) begin
      @(negedge clk);
      if (bus.USR_ENA === 1'b1) begin
        o_seen = 1'b1; o_wcyc = i + 1;
        o_addr = bus.USR_ADDR; o_wdata = bus.USR_WDATA; o_wstb = bus.USR_WSTB;
        o_gnt  = bus.GNT_ID;
      end
    end
    if (o_seen) begin
      bus.USR_RDATA = rd; bus.USR_RRESP = rr; bus.USR_DONE = 1'b1;
      @(negedge clk);
      bus.USR_DONE = 1'b0;
      o_ena2 = bus.USR_ENA; o_dv = bus.REQ_DONE; o_rd = bus.REQ_RDATA; o_rr = bus.REQ_RRESP;
    end
  endtask

  task test_reset;
    rst_n = 1'b0;
    bus.REQ_ENA = '0; bus.REQ_WSTB = '0; bus.REQ_ADDR = '0; bus.REQ_WDATA = '0;
    bus.USR_RDATA = '0; bus.USR_RRESP = '0; bus.USR_DONE = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    n_tests++; if (bus.USR_ENA !== 1'b0) begin n_fail++; $display("FAIL reset_usr_ena: got %b want 0", bus.USR_ENA); end
    n_tests++; if (bus.REQ_DONE !== 2'b00) begin n_fail++; $display("FAIL reset_req_done: got %b want 00", bus.REQ_DONE); end
    n_tests++; if (bus.GNT_ID !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %h want 0", bus.GNT_ID); end
    n_tests++; if (bus.USR_ADDR !== 32'h0) begin n_fail++; $display("FAIL reset_usr_addr: got %h want 0", bus.USR_ADDR); end
    n_tests++; if (bus.REQ_RRESP !== 2'b00) begin n_fail++; $display("FAIL reset_rresp: got %b want 00", bus.REQ_RRESP); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task test_single_read;
    bus.REQ_WSTB[3:0] = 4'h0; bus.REQ_ADDR[31:0] = 32'h1000; bus.REQ_ENA = 2'b01;
    @(negedge clk);
    n_tests++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL rd_busy: got %b want 1", bus.BUSY); end
    n_tests++; if (bus.GNT_ID !== 1'b0) begin n_fail++; $display("FAIL rd_gnt_early: got %h want 0", bus.GNT_ID); end
    n_tests++; if (bus.USR_ADDR !== 32'h1000) begin n_fail++; $display("FAIL rd_addr_early: got %h want 1000", bus.USR_ADDR); end
    n_tests++; if (bus.USR_ENA !== 1'b0) begin n_fail++; $display("FAIL rd_ena_early: got %b want 0", bus.USR_ENA); end
    serve(32'hDEADBEEF, 2'b00);
    bus.REQ_ENA = 2'b00;
    n_tests++; if (o_seen !== 1'b1) begin n_fail++; $display("FAIL rd_ena_seen: got %b want 1", o_seen); end
    n_tests++; if (o_wcyc != 1) begin n_fail++; $display("FAIL rd_ena_latency: got %0d want 1", o_wcyc); end
    n_tests++; if (o_ena2 !== 1'b0) begin n_fail++; $display("FAIL rd_ena_width: got %b want 0", o_ena2); end
    n_tests++; if (o_wstb !== 4'h0) begin n_fail++; $display("FAIL rd_wstb: got %h want 0", o_wstb); end
    n_tests++; if (o_dv !== 2'b01) begin n_fail++; $display("FAIL rd_done: got %b want 01", o_dv); end
    n_tests++; if (o_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", o_rd); end
    n_tests++; if (o_rr !== 2'b00) begin n_fail++; $display("FAIL rd_rresp: got %b want 00", o_rr); end
    @(negedge clk);
    n_tests++; if (bus.REQ_DONE !== 2'b00) begin n_fail++; $display("FAIL rd_done_clear: got %b want 00", bus.REQ_DONE); end
    n_tests++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rd_busy_clear: got %b want 0", bus.BUSY); end
  endtask

  task test_contention;
    logic [0:0]  eg;
    logic [1:0]  ed;
    logic [31:0] ea;
    rst_n = 1'b0;
    bus.REQ_ADDR = {32'h200, 32'h100}; bus.REQ_WSTB = '0; bus.REQ_ENA = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 1) ? 1'b1 : 1'b0;
      ed = eg ? 2'b10 : 2'b01;
      ea = eg ? 32'h200 : 32'h100;
      serve(32'h1000 + k, 2'b00);
      n_tests++; if (o_seen !== 1'b1) begin n_fail++; $display("FAIL cont_seen[%0d]: got %b want 1", k, o_seen); end
      n_tests++; if (o_gnt !== eg) begin n_fail++; $display("FAIL cont_gnt[%0d]: got %h want %h", k, o_gnt, eg); end
      n_tests++; if (o_addr !== ea) begin n_fail++; $display("FAIL cont_addr[%0d]: got %h want %h", k, o_addr, ea); end
      n_tests++; if (o_dv !== ed) begin n_fail++; $display("FAIL cont_done[%0d]: got %b want %b", k, o_dv, ed); end
      n_tests++; if (o_rd !== 32'h1000 + k) begin n_fail++; $display("FAIL cont_rdata[%0d]: got %h want %h", k, o_rd, 32'h1000 + k); end
      if (k > 0) begin
        n_tests++; if (o_wcyc != 3) begin n_fail++; $display("FAIL cont_turnaround[%0d]: got %0d want 3", k, o_wcyc); end
      end
    end
  endtask

  task test_write;
    bus.REQ_WSTB[7:4] = 4'hF; bus.REQ_ADDR[63:32] = 32'h20; bus.REQ_WDATA[63:32] = 32'h12345678;
    bus.REQ_ENA = 2'b10;
    serve(32'h0, 2'b10);
    bus.REQ_ENA = 2'b00;
    n_tests++; if (o_seen !== 1'b1) begin n_fail++; $display("FAIL wr_seen: got %b want 1", o_seen); end
    n_tests++; if (o_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %h want 1", o_gnt); end
    n_tests++; if (o_wstb !== 4'hF) begin n_fail++; $display("FAIL wr_wstb: got %h want f", o_wstb); end
    n_tests++; if (o_addr !== 32'h20) begin n_fail++; $display("FAIL wr_addr: got %h want 20", o_addr); end
    n_tests++; if (o_wdata !== 32'h12345678) begin n_fail++; $display("FAIL wr_wdata: got %h want 12345678", o_wdata); end
    n_tests++; if (o_dv !== 2'b10) begin n_fail++; $display("FAIL wr_done: got %b want 10", o_dv); end
    n_tests++; if (o_rr !== 2'b10) begin n_fail++; $display("FAIL wr_rresp: got %b want 10", o_rr); end
  endtask

  task test_stray_done;
    repeat (3) @(negedge clk);
    bus.USR_RDATA = 32'hBAD0BAD0; bus.USR_RRESP = 2'b11; bus.USR_DONE = 1'b1;
    @(negedge clk);
    bus.USR_DONE = 1'b0;
    n_tests++; if (bus.REQ_DONE !== 2'b00) begin n_fail++; $display("FAIL stray_done: got %b want 00", bus.REQ_DONE); end
    n_tests++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL stray_busy: got %b want 0", bus.BUSY); end
    n_tests++; if (bus.REQ_RDATA !== 32'h0) begin n_fail++; $display("FAIL stray_rdata: got %h want 0", bus.REQ_RDATA); end
    n_tests++; if (bus.REQ_RRESP !== 2'b10) begin n_fail++; $display("FAIL stray_rresp: got %b want 10", bus.REQ_RRESP); end
    @(negedge clk);
    n_tests++; if (bus.USR_ENA !== 1'b0) begin n_fail++; $display("FAIL stray_ena: got %b want 0", bus.USR_ENA); end
  endtask

  task test_reset_mid_wait;
    logic seen;
    // Complete one for requester 0 so an un-reset last_gnt would favour requester 1
    bus.REQ_ADDR[31:0] = 32'h40; bus.REQ_WSTB = '0; bus.REQ_ENA = 2'b01;
    serve(32'hA5A50001, 2'b00);
    bus.REQ_ENA = 2'b00;
    n_tests++; if (o_dv !== 2'b01) begin n_fail++; $display("FAIL rst_pre_done: got %b want 01", o_dv); end
    bus.REQ_ADDR[63:32] = 32'h80; bus.REQ_WSTB[7:4] = 4'h3; bus.REQ_WDATA[63:32] = 32'hCAFE;
    bus.REQ_ENA = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.USR_ENA === 1'b1) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_wait_seen: got %b want 1", seen); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.BUSY); end
    n_tests++; if (bus.GNT_ID !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %h want 0", bus.GNT_ID); end
    n_tests++; if (bus.USR_ADDR !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.USR_ADDR); end
    n_tests++; if (bus.USR_WSTB !== 4'h0) begin n_fail++; $display("FAIL rst_wstb: got %h want 0", bus.USR_WSTB); end
    n_tests++; if (bus.USR_WDATA !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", bus.USR_WDATA); end
    n_tests++; if (bus.REQ_RDATA !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.REQ_RDATA); end
    n_tests++; if (bus.REQ_DONE !== 2'b00) begin n_fail++; $display("FAIL rst_done: got %b want 00", bus.REQ_DONE); end
    bus.REQ_ADDR[31:0] = 32'h44; bus.REQ_ENA = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    serve(32'h00005A5A, 2'b00);
    bus.REQ_ENA = 2'b00;
    n_tests++; if (o_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_next_gnt: got %h want 0", o_gnt); end
    n_tests++; if (o_addr !== 32'h44) begin n_fail++; $display("FAIL rst_next_addr: got %h want 44", o_addr); end
    n_tests++; if (o_dv !== 2'b01) begin n_fail++; $display("FAIL rst_next_done: got %b want 01", o_dv); end
  endtask

`ifdef AXILM_ARB_TIMEOUT_EN
  task test_timeout;
    logic seen, got;
    int   cyc;
    repeat (2) @(negedge clk);
    bus.REQ_ADDR[31:0] = 32'h60; bus.REQ_ENA = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.USR_ENA === 1'b1) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL to_ena_seen: got %b want 1", seen); end
    got = 1'b0; cyc = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (bus.REQ_DONE !== 2'b00) begin got = 1'b1; cyc = i; end
    end
    n_tests++; if (cyc != 16) begin n_fail++; $display("FAIL to_latency: got %0d want 16", cyc); end
    n_tests++; if (bus.REQ_DONE !== 2'b01) begin n_fail++; $display("FAIL to_done: got %b want 01", bus.REQ_DONE); end
    n_tests++; if (bus.REQ_RRESP !== 2'b10) begin n_fail++; $display("FAIL to_rresp: got %b want 10", bus.REQ_RRESP); end
    n_tests++; if (bus.REQ_RDATA !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", bus.REQ_RDATA); end
    bus.REQ_ENA = 2'b00;
    repeat (2) @(negedge clk);
    bus.USR_RDATA = 32'h11112222; bus.USR_DONE = 1'b1;
    @(negedge clk);
    bus.USR_DONE = 1'b0;
    n_tests++; if (bus.REQ_DONE !== 2'b00) begin n_fail++; $display("FAIL to_late_done: got %b want 00", bus.REQ_DONE); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_stray_done();
    test_reset_mid_wait();
`ifdef AXILM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
